// File: rtl/traffic_phase_ctrl.sv
// Two-road intersection phase sequencer: per-phase countdown, lamps, WALK and night flash.
module traffic_phase_ctrl #(
   parameter int unsigned W         = 6,
   parameter int unsigned PED_GREEN = 5
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         tick,
   input  logic         night_mode,
   input  logic         ped_req,
   input  logic [W-1:0] t_main_g,
   input  logic [W-1:0] t_side_g,
   input  logic [W-1:0] t_yellow,
   input  logic [W-1:0] t_allred,
   output logic [2:0]   main_light,
   output logic [2:0]   side_light,
   output logic         ped_walk,
   output logic [W-1:0] remain,
   output logic [2:0]   phase
);

   typedef enum logic [2:0] {
      PH_AR_S2M = 3'd0,
      PH_MAIN_G = 3'd1,
      PH_MAIN_Y = 3'd2,
      PH_AR_M2S = 3'd3,
      PH_SIDE_G = 3'd4,
      PH_SIDE_Y = 3'd5,
      PH_NIGHT  = 3'd6
   } phase_e;

   localparam logic [2:0] LAMP_R   = 3'b100;
   localparam logic [2:0] LAMP_Y   = 3'b010;
   localparam logic [2:0] LAMP_G   = 3'b001;
   localparam logic [2:0] LAMP_OFF = 3'b000;

   phase_e       phase_q, phase_d;
   logic [W-1:0] remain_q, remain_d;
   logic         flash_q, flash_d;
   logic         ped_pend_q, ped_pend_d;
   logic         walk_q, walk_d;
   logic [2:0]   main_q, main_d;
   logic [2:0]   side_q, side_d;
   logic         enter_side_g;

   // A zero duration still occupies one tick.
   function automatic logic [W-1:0] at_least_one(input logic [W-1:0] dur);
      return (dur == '0) ? W'(1) : dur;
   endfunction

   // State register; every output is a flop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase_q    <= PH_AR_S2M;
         remain_q   <= '0;
         flash_q    <= 1'b0;
         ped_pend_q <= 1'b0;
         walk_q     <= 1'b0;
         main_q     <= LAMP_R;
         side_q     <= LAMP_R;
      end else begin
         phase_q    <= phase_d;
         remain_q   <= remain_d;
         flash_q    <= flash_d;
         ped_pend_q <= ped_pend_d;
         walk_q     <= walk_d;
         main_q     <= main_d;
         side_q     <= side_d;
      end
   end

   // Next phase / countdown on tick, pedestrian bookkeeping and lamp decode of the next state.
   always_comb begin
      phase_d  = phase_q;
      remain_d = remain_q;
      flash_d  = flash_q;
      main_d   = LAMP_R;
      side_d   = LAMP_R;

      if (tick) begin
         if (phase_q == PH_NIGHT) begin
            if (night_mode) begin
               flash_d = ~flash_q;
            end else begin
               phase_d  = PH_AR_S2M;
               remain_d = at_least_one(t_allred);
               flash_d  = 1'b0;
            end
         end else if (remain_q <= W'(1)) begin
            if (night_mode) begin
               phase_d  = PH_NIGHT;
               remain_d = '0;
               flash_d  = 1'b1;
            end else begin
               case (phase_q)
                  PH_AR_S2M: begin phase_d = PH_MAIN_G; remain_d = at_least_one(t_main_g); end
                  PH_MAIN_G: begin phase_d = PH_MAIN_Y; remain_d = at_least_one(t_yellow); end
                  PH_MAIN_Y: begin phase_d = PH_AR_M2S; remain_d = at_least_one(t_allred); end
                  PH_AR_M2S: begin phase_d = PH_SIDE_G; remain_d = at_least_one(t_side_g); end
                  PH_SIDE_G: begin phase_d = PH_SIDE_Y; remain_d = at_least_one(t_yellow); end
                  default:   begin phase_d = PH_AR_S2M; remain_d = at_least_one(t_allred); end
               endcase
            end
         end else if (phase_q == PH_MAIN_G && ped_pend_q && remain_q > W'(PED_GREEN)) begin
            // Pending crossing request shortens main green; it can only shrink the phase.
            remain_d = W'(PED_GREEN);
         end else begin
            remain_d = remain_q - W'(1);
         end
      end

      // A new request in the entry cycle survives the clear.
      enter_side_g = (phase_d == PH_SIDE_G) && (phase_q != PH_SIDE_G);
      ped_pend_d   = ped_req | (ped_pend_q & ~enter_side_g);
      walk_d       = (phase_d == PH_SIDE_G) ? (enter_side_g ? ped_pend_q : walk_q) : 1'b0;

      case (phase_d)
         PH_MAIN_G: main_d = LAMP_G;
         PH_MAIN_Y: main_d = LAMP_Y;
         PH_SIDE_G: side_d = LAMP_G;
         PH_SIDE_Y: side_d = LAMP_Y;
         PH_NIGHT: begin
            main_d = flash_d ? LAMP_Y : LAMP_OFF;
            side_d = flash_d ? LAMP_Y : LAMP_OFF;
         end
         default: ;
      endcase
   end

   assign phase      = phase_q;
   assign remain     = remain_q;
   assign main_light = main_q;
   assign side_light = side_q;
   assign ped_walk   = walk_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl: vector table for the plain ring, hand sequences for the rest.
module tb_traffic_phase_ctrl;

   localparam int unsigned W = 6;
   localparam logic [2:0] R = 3'b100;
   localparam logic [2:0] Y = 3'b010;
   localparam logic [2:0] G = 3'b001;
   localparam logic [2:0] O = 3'b000;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         tick = 1'b0;
   logic         night_mode = 1'b0;
   logic         ped_req = 1'b0;
   logic [W-1:0] t_main_g = 6'd10;
   logic [W-1:0] t_side_g = 6'd8;
   logic [W-1:0] t_yellow = 6'd3;
   logic [W-1:0] t_allred = 6'd2;
   logic [2:0]   main_light, side_light;
   logic         ped_walk;
   logic [W-1:0] remain;
   logic [2:0]   phase;

   int total = 0;
   int bad   = 0;

   traffic_phase_ctrl #(.W(W), .PED_GREEN(5)) dut (
      .clk(clk), .reset_n(reset_n), .tick(tick), .night_mode(night_mode), .ped_req(ped_req),
      .t_main_g(t_main_g), .t_side_g(t_side_g), .t_yellow(t_yellow), .t_allred(t_allred),
      .main_light(main_light), .side_light(side_light), .ped_walk(ped_walk),
      .remain(remain), .phase(phase)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         n;
      logic [2:0] ph;
      logic [5:0] rem;
      logic [2:0] ml;
      logic [2:0] sl;
      logic       wk;
   } vec_t;

   vec_t tbl[8];

   // One clock cycle, inputs changed only at the falling edge.
   task automatic cyc(input logic tk);
      tick = tk;
      @(posedge clk);
      @(negedge clk);
      tick = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) cyc(1'b1);
   endtask

   task automatic check(input string nm, input logic [2:0] ph, input logic [5:0] rem,
                        input logic [2:0] ml, input logic [2:0] sl, input logic wk);
      logic [15:0] act, want;
      act  = {phase, remain, main_light, side_light, ped_walk};
      want = {ph, rem, ml, sl, wk};
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got phase=%0d remain=%0d main=%b side=%b walk=%b, want phase=%0d remain=%0d main=%b side=%b walk=%b",
                  nm, phase, remain, main_light, side_light, ped_walk, ph, rem, ml, sl, wk);
      end
   endtask

   // Conflicting greens/yellows must never appear outside night operation.
   always @(negedge clk) begin
      if (reset_n && phase != 3'd6) begin
         total++;
         if (main_light != R && side_light != R) begin
            bad++;
            $display("FAIL conflict: got main=%b side=%b in phase %0d, want one road red",
                     main_light, side_light, phase);
         end
      end
   end

   initial begin
      tbl[0] = '{0, 3'd0, 6'd0,  R, R, 1'b0};
      tbl[1] = '{1, 3'd1, 6'd10, G, R, 1'b0};
      tbl[2] = '{9, 3'd1, 6'd1,  G, R, 1'b0};
      tbl[3] = '{1, 3'd2, 6'd3,  Y, R, 1'b0};
      tbl[4] = '{3, 3'd3, 6'd2,  R, R, 1'b0};
      tbl[5] = '{2, 3'd4, 6'd8,  R, G, 1'b0};
      tbl[6] = '{8, 3'd5, 6'd3,  R, Y, 1'b0};
      tbl[7] = '{3, 3'd0, 6'd2,  R, R, 1'b0};

      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // Plain ring with 10/3/2/8 durations
      for (int i = 0; i < 8; i++) begin
         ticks(tbl[i].n);
         check($sformatf("ring%0d", i), tbl[i].ph, tbl[i].rem, tbl[i].ml, tbl[i].sl, tbl[i].wk);
      end

      // Pedestrian clamp and WALK
      ticks(2);  check("ped_mg_entry", 3'd1, 6'd10, G, R, 1'b0);
      ticks(1);  check("ped_mg_9", 3'd1, 6'd9, G, R, 1'b0);
      ped_req = 1'b1; cyc(1'b0); ped_req = 1'b0;
      check("no_tick_hold", 3'd1, 6'd9, G, R, 1'b0);
      ticks(1);  check("ped_clamp", 3'd1, 6'd5, G, R, 1'b0);
      ticks(4);  check("ped_mg_1", 3'd1, 6'd1, G, R, 1'b0);
      ticks(6);  check("ped_walk_on", 3'd4, 6'd8, R, G, 1'b1);
      ticks(8);  check("ped_walk_off", 3'd5, 6'd3, R, Y, 1'b0);
      ticks(20); check("ped_next_sg", 3'd4, 6'd8, R, G, 1'b0);

      // Night operation entered only at phase end
      ticks(19); check("night_mg_4", 3'd1, 6'd4, G, R, 1'b0);
      night_mode = 1'b1;
      ticks(3);  check("night_wait", 3'd1, 6'd1, G, R, 1'b0);
      ticks(1);  check("night_on", 3'd6, 6'd0, Y, Y, 1'b0);
      ticks(1);  check("night_off", 3'd6, 6'd0, O, O, 1'b0);
      cyc(1'b0); check("night_hold", 3'd6, 6'd0, O, O, 1'b0);
      night_mode = 1'b0;
      ticks(1);  check("night_exit", 3'd0, 6'd2, R, R, 1'b0);

      // Zero yellow and mid-phase config change
      t_yellow = 6'd0;
      ticks(3);  t_main_g = 6'd3;
      ticks(1);  check("cfg_mid", 3'd1, 6'd8, G, R, 1'b0);
      ticks(8);  check("yel0_main", 3'd2, 6'd1, Y, R, 1'b0);
      ticks(1);  check("yel0_ar", 3'd3, 6'd2, R, R, 1'b0);
      ticks(10); check("yel0_side", 3'd5, 6'd1, R, Y, 1'b0);
      ticks(3);  check("cfg_new", 3'd1, 6'd3, G, R, 1'b0);
      t_yellow = 6'd3; t_main_g = 6'd10;

      // Request coincident with SIDE_G entry, then async reset
      ticks(7);  check("ar_last", 3'd3, 6'd1, R, R, 1'b0);
      ped_req = 1'b1; cyc(1'b1); ped_req = 1'b0;
      check("sg_same_cycle", 3'd4, 6'd8, R, G, 1'b0);
      ticks(13); check("pend_kept_mg", 3'd1, 6'd10, G, R, 1'b0);
      ticks(1);  check("pend_kept_clamp", 3'd1, 6'd5, G, R, 1'b0);
      ticks(10); check("pend_walk", 3'd4, 6'd8, R, G, 1'b1);
      ticks(2);
      ped_req = 1'b1; cyc(1'b0); ped_req = 1'b0;
      check("pre_reset", 3'd4, 6'd6, R, G, 1'b1);
      #2 reset_n = 1'b0;
      #1 check("async_reset", 3'd0, 6'd0, R, R, 1'b0);
      #1 reset_n = 1'b1;
      @(negedge clk);
      ticks(1);  check("post_reset_mg", 3'd1, 6'd10, G, R, 1'b0);
      ticks(1);  check("pend_cleared", 3'd1, 6'd9, G, R, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
